// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS32 control unit: opcodes, states, datapath selects.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StRExec   = 4'd2,
    StRWb     = 4'd3,
    StMemAddr = 4'd4,
    StMemRd   = 4'd5,
    StMemWb   = 4'd6,
    StMemWr   = 4'd7,
    StIExec   = 4'd8,
    StIWb     = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational control-vector decoder: current state (plus mem_ready, opcode) to datapath
// selects and strobes.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e      i_state,
  input  logic        i_mem_ready,
  input  logic [5:0]  i_opcode,
  output ctrl_t       o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      StFetch: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      StDecode: begin
        // Branch target is computed speculatively into ALUOut here.
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.illegal   = ~is_legal_op(i_opcode);
      end
      StRExec: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RT;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      StRWb: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      StMemAddr: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      StMemRd: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      StMemWb: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      StMemWr: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      StIExec, StIWb: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = (i_opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
        o_ctrl.reg_write = (i_state == StIWb);
      end
      StBranch: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_RT;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.branch_ne     = i_opcode[0];
      end
      StJump: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS32 control FSM: state register and next-state logic; outputs come from
// mips_ctrl_outdec and are forced to zero while reset is held.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W            = 4,
  parameter int unsigned FETCH_ONLY_ILLEGAL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               BranchNE,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  localparam bit IllegalEn = (FETCH_ONLY_ILLEGAL != 0);

  state_e r_state;
  state_e w_state_next;
  ctrl_t  w_ctrl;
  ctrl_t  w_ctrl_gated;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = StFetch;
    case (r_state)
      StFetch:  w_state_next = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (Opcode)
          OP_RTYPE:        w_state_next = StRExec;
          OP_LW, OP_SW:    w_state_next = StMemAddr;
          OP_ADDI, OP_SLTI: w_state_next = StIExec;
          OP_BEQ, OP_BNE:  w_state_next = StBranch;
          OP_J:            w_state_next = StJump;
          default:         w_state_next = StFetch;
        endcase
      end
      StRExec:   w_state_next = StRWb;
      StRWb:     w_state_next = StFetch;
      StMemAddr: begin
        if (Opcode == OP_LW) begin
          w_state_next = StMemRd;
        end else if (Opcode == OP_SW) begin
          w_state_next = StMemWr;
        end else begin
          w_state_next = StFetch;
        end
      end
      StMemRd:  w_state_next = mem_ready ? StMemWb : StMemRd;
      StMemWb:  w_state_next = StFetch;
      StMemWr:  w_state_next = mem_ready ? StFetch : StMemWr;
      StIExec:  w_state_next = StIWb;
      StIWb:    w_state_next = StFetch;
      StBranch: w_state_next = StFetch;
      StJump:   w_state_next = StFetch;
      default:  w_state_next = StFetch;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .i_opcode    (Opcode),
    .o_ctrl      (w_ctrl)
  );

  // Reset masks strobes immediately, not just from the next edge.
  assign w_ctrl_gated = rst ? '0 : w_ctrl;

  assign PCWrite     = w_ctrl_gated.pc_write;
  assign PCWriteCond = w_ctrl_gated.pc_write_cond;
  assign BranchNE    = w_ctrl_gated.branch_ne;
  assign IorD        = w_ctrl_gated.i_or_d;
  assign MemRead     = w_ctrl_gated.mem_read;
  assign MemWrite    = w_ctrl_gated.mem_write;
  assign IRWrite     = w_ctrl_gated.ir_write;
  assign MemToReg    = w_ctrl_gated.mem_to_reg;
  assign RegDst      = w_ctrl_gated.reg_dst;
  assign RegWrite    = w_ctrl_gated.reg_write;
  assign ALUSrcA     = w_ctrl_gated.alu_src_a;
  assign ALUSrcB     = w_ctrl_gated.alu_src_b;
  assign ALUOp       = w_ctrl_gated.alu_op;
  assign PCSource    = w_ctrl_gated.pc_source;
  assign illegal_op  = w_ctrl_gated.illegal & IllegalEn;
  assign state_o     = STATE_W'(r_state);

endmodule
